rotate_buffer: RTL and testbench



---
 rtl/rotate_buffer_pkg.sv | 31 +++
 rtl/rotate_buffer_if.sv | 38 +++
 rtl/rotate_buffer_hex_to_seg.sv | 39 +++
 rtl/rotate_buffer.sv | 117 +++++++++++
 tb/tb_rotate_buffer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/rotate_buffer_pkg.sv
// rotate_buffer_pkg
//   Shared definitions for the rotate_buffer datapath stage. The controller
//   state codes (IDLE/LOAD/ROTATE) come from the load/rotate controller and
//   must stay bit-identical to it. The code 2'd3 is illegal and has no enum
//   member.
//   Also holds the buffer geometry (8 digits of 4 bits) and the circular
//   rotate helper.
package rotate_buffer_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int NIB_W      = 4;
  localparam int IDX_W      = 3;
  localparam int BUF_W      = NUM_DIGITS * NIB_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ROTATE = 2'd2
  } ctrl_state_e;

  // dir=0 rotates left (slot i takes slot i-1, slot 0 takes slot 7).
  // dir=1 rotates right (slot i takes slot i+1, slot 7 takes slot 0).
  function automatic logic [BUF_W-1:0] rotate_nibbles(input logic [BUF_W-1:0] d,
                                                      input logic             dir);
    if (dir)
      return {d[NIB_W-1:0], d[BUF_W-1:NIB_W]};
    else
      return {d[BUF_W-NIB_W-1:0], d[BUF_W-1:BUF_W-NIB_W]};
  endfunction

endpackage

// File: rtl/rotate_buffer_if.sv
// rotate_buffer_if
//   Bus between the load/rotate controller side (master) and the
//   rotate_buffer stage (slave).
//   Controller -> buffer:
//     state[1:0]          controller state code
//     load_position[2:0]  slot written on a LOAD strobe
//     load_rotate         single-cycle strobe
//     data_in[3:0]        nibble to store
//     dir                 rotation direction (0 = left, 1 = right)
//   Buffer -> controller / display:
//     digits[31:0]        buffer contents, slot i on [4i+3:4i]
//     rot_tick            one-cycle pulse on every rotation
//     an[7:0]             one-hot active-low digit enable
//     seg_data[6:0]       segment pattern or raw nibble (see rotate_buffer)
interface rotate_buffer_if;
  import rotate_buffer_pkg::*;

  logic [1:0]       state;
  logic [IDX_W-1:0] load_position;
  logic             load_rotate;
  logic [NIB_W-1:0] data_in;
  logic             dir;
  logic [BUF_W-1:0] digits;
  logic             rot_tick;
  logic [7:0]       an;
  logic [6:0]       seg_data;

  modport master (
    output state, load_position, load_rotate, data_in, dir,
    input  digits, rot_tick, an, seg_data
  );

  modport slave (
    input  state, load_position, load_rotate, data_in, dir,
    output digits, rot_tick, an, seg_data
  );

endinterface

// File: rtl/rotate_buffer_hex_to_seg.sv
// hex_to_seg
//   Combinational hex nibble to 7-segment decoder.
//   The output is active-low, ordered {g,f,e,d,c,b,a}.
//   Only compiled when SEG_DECODE_EN is defined, because rotate_buffer
//   instantiates it only in that build.
//   Ports:
//     nibble[3:0]  input  hex value 0..F
//     seg[6:0]     output active-low segment pattern
`ifdef SEG_DECODE_EN
module hex_to_seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule
`endif

// File: rtl/rotate_buffer.sv
// rotate_buffer
//   Datapath stage behind the load/rotate controller.
//   In LOAD, each load_rotate strobe writes data_in into slot load_position.
//   In ROTATE, the 8-nibble buffer is rotated circularly once every ROT_DIV
//   cycles, and rot_tick pulses in the cycle before each rotation edge.
//   A free-running scan multiplexes the buffer onto an 8-digit display. Each
//   digit is held for SCAN_DIV cycles.
//   Build option: define SEG_DECODE_EN to drive seg_data with active-low
//   7-segment patterns. When it is undefined, seg_data carries the raw
//   nibble as {3'b000, nibble}.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset; clears buffer, counters and scan
//     bus    rotate_buffer_if.slave (controller inputs, display outputs)
module rotate_buffer
  import rotate_buffer_pkg::*;
#(
  parameter int ROT_DIV  = 50_000_000,
  parameter int SCAN_DIV = 100_000,
  parameter int CNT_W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  rotate_buffer_if.slave  bus
);

  localparam logic [CNT_W-1:0] ROT_LAST  = CNT_W'(ROT_DIV - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

`ifdef SEG_DECODE_EN
  localparam logic [6:0] SEG_RST = 7'b1000000;
`else
  localparam logic [6:0] SEG_RST = 7'b0000000;
`endif

  logic [BUF_W-1:0] buf_q;
  logic [CNT_W-1:0] rot_cnt_q;
  logic [CNT_W-1:0] scan_cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       an_q;
  logic [6:0]       seg_q;

  logic             in_load;
  logic             in_rotate;
  logic             rot_now;
  logic [IDX_W-1:0] idx_nxt;
  logic [NIB_W-1:0] nib_sel;
  logic [6:0]       seg_nxt;

  assign in_load   = (bus.state == ST_LOAD);
  assign in_rotate = (bus.state == ST_ROTATE);

  // The illegal code 2'd3 matches neither state, so it neither writes nor
  // rotates, and it keeps the divider cleared.
  assign rot_now = in_rotate && (rot_cnt_q == ROT_LAST);

  // an and seg_data are both registered from the upcoming index, so they
  // switch on the same edge.
  assign idx_nxt = (scan_cnt_q == SCAN_LAST) ? idx_q + IDX_W'(1) : idx_q;
  assign nib_sel = buf_q[{idx_nxt, 2'b00} +: NIB_W];

`ifdef SEG_DECODE_EN
  logic [6:0] seg_dec;

  hex_to_seg u_hex_to_seg (
    .nibble (nib_sel),
    .seg    (seg_dec)
  );

  assign seg_nxt = seg_dec;
`else
  assign seg_nxt = {3'b000, nib_sel};
`endif

  // ---- buffer write / rotate ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else if (in_load && bus.load_rotate) begin
      buf_q[{bus.load_position, 2'b00} +: NIB_W] <= bus.data_in;
    end else if (rot_now) begin
      buf_q <= rotate_nibbles(buf_q, bus.dir);
    end
  end

  // ---- rotation divider ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_cnt_q <= '0;
    end else if (!in_rotate || rot_now) begin
      rot_cnt_q <= '0;
    end else begin
      rot_cnt_q <= rot_cnt_q + CNT_W'(1);
    end
  end

  // ---- display scan ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      an_q       <= 8'b1111_1110;
      seg_q      <= SEG_RST;
    end else begin
      scan_cnt_q <= (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + CNT_W'(1);
      idx_q      <= idx_nxt;
      an_q       <= ~(8'd1 << idx_nxt);
      seg_q      <= seg_nxt;
    end
  end

  assign bus.digits   = buf_q;
  assign bus.rot_tick = rot_now;
  assign bus.an       = an_q;
  assign bus.seg_data = seg_q;

endmodule

// File: tb/tb_rotate_buffer.sv
// tb_rotate_buffer
//   Scoreboard bench for rotate_buffer (ROT_DIV=4, SCAN_DIV=3).
//   Before each clock edge, the expected post-edge outputs are pushed into a
//   queue. They are popped and compared 1 ns after the edge.
module tb_rotate_buffer;
  import rotate_buffer_pkg::*;

  localparam int ROT_DIV  = 4;
  localparam int SCAN_DIV = 3;
  localparam int CNT_W    = 8;

`ifdef SEG_DECODE_EN
  localparam logic [6:0] SEG8 = 7'b0000000;
`else
  localparam logic [6:0] SEG8 = 7'h08;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rotate_buffer_if bus ();

  rotate_buffer #(
    .ROT_DIV  (ROT_DIV),
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] digits;
    logic        tick;
    logic [7:0]  an;
    logic [6:0]  seg;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [31:0] m_buf;
  int          m_cnt;
  int          m_scnt;
  logic [2:0]  m_idx;

  function automatic logic [6:0] enc(input logic [3:0] n);
`ifdef SEG_DECODE_EN
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
`else
    return {3'b000, n};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_buf  = '0;
    m_cnt  = 0;
    m_scnt = 0;
    m_idx  = '0;
    sb_q.delete();
  endtask

  // One clock: predict, push, wait for the edge, pop and compare.
  task automatic step(input string tag);
    exp_t        e;
    exp_t        g;
    logic [31:0] nb;
    int          nc;
    nb = m_buf;
    if (bus.state == 2'd1 && bus.load_rotate) begin
      nb[int'(bus.load_position)*4 +: 4] = bus.data_in;
    end else if (bus.state == 2'd2 && m_cnt == ROT_DIV-1) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.dir) nb[i*4 +: 4] = m_buf[((i+1)%8)*4 +: 4];
        else         nb[i*4 +: 4] = m_buf[((i+7)%8)*4 +: 4];
      end
    end
    nc = (bus.state == 2'd2) ? (m_cnt + 1) % ROT_DIV : 0;
    if (m_scnt == SCAN_DIV-1) begin
      m_scnt = 0;
      m_idx  = m_idx + 3'd1;
    end else begin
      m_scnt = m_scnt + 1;
    end
    e.an     = ~(8'd1 << m_idx);
    e.seg    = enc(m_buf[int'(m_idx)*4 +: 4]);
    e.digits = nb;
    e.tick   = (bus.state == 2'd2) && (nc == ROT_DIV-1);
    m_buf    = nb;
    m_cnt    = nc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    check({tag, ".digits"}, bus.digits, g.digits);
    check({tag, ".tick"}, {31'd0, bus.rot_tick}, {31'd0, g.tick});
    check({tag, ".an"}, {24'd0, bus.an}, {24'd0, g.an});
    check({tag, ".seg"}, {25'd0, bus.seg_data}, {25'd0, g.seg});
  endtask

  task automatic strobe(input logic [1:0] st, input logic [2:0] pos, input logic [3:0] d,
                        input string tag);
    bus.state         = st;
    bus.load_position = pos;
    bus.data_in       = d;
    bus.load_rotate   = 1'b1;
    step(tag);
    bus.load_rotate   = 1'b0;
  endtask

  task automatic fill();
    for (int p = 0; p < 8; p++) strobe(2'd1, 3'(p), 4'(p + 1), "load");
  endtask

  initial begin
    bus.state         = 2'd0;
    bus.load_position = '0;
    bus.load_rotate   = 1'b0;
    bus.data_in       = '0;
    bus.dir           = 1'b0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.digits", bus.digits, 32'h0);
    check("rst.an", {24'd0, bus.an}, 32'hFE);
    check("rst.tick", {31'd0, bus.rot_tick}, 32'd0);
    check("rst.seg", {25'd0, bus.seg_data}, {25'd0, enc(4'h0)});
    rst_n = 1'b1;

    // strobe in IDLE stores nothing, then load 1..8
    strobe(2'd0, 3'd0, 4'hF, "idle_strobe");
    fill();
    check("loaded", bus.digits, 32'h8765_4321);

    // strobes in ROTATE and in the illegal state are ignored
    strobe(2'd2, 3'd3, 4'hF, "rot_strobe");
    strobe(2'd3, 3'd4, 4'hF, "ill_strobe");
    check("no_write", bus.digits, 32'h8765_4321);
    bus.state = 2'd0;
    step("idle");

    // left rotation
    bus.state = 2'd2;
    bus.dir   = 1'b0;
    repeat (3) step("left");
    check("left.tick_on", {31'd0, bus.rot_tick}, 32'd1);
    step("left");
    check("left.first", bus.digits, 32'h7654_3218);
    repeat (4) step("left");
    check("left.second", bus.digits, 32'h6543_2187);

    // right rotation from a fresh load
    bus.state = 2'd0;
    step("idle");
    fill();
    bus.state = 2'd2;
    bus.dir   = 1'b1;
    repeat (4) step("right");
    check("right.first", bus.digits, 32'h1876_5432);

    // leave ROTATE after 2 cycles, then re-enter: counter restarts
    repeat (2) step("pre_leave");
    bus.state = 2'd0;
    step("leave");
    bus.state = 2'd2;
    repeat (3) step("reenter");
    check("reenter.tick", {31'd0, bus.rot_tick}, 32'd1);
    step("reenter");
    check("reenter.rot", bus.digits, 32'h2187_6543);

    // scan in IDLE and in the illegal state; slot 5 holds 8
    bus.state = 2'd0;
    for (int i = 0; i < 30; i++) begin
      step("scan");
      if (bus.an == 8'hDF) check("scan.digit8", {25'd0, bus.seg_data}, {25'd0, SEG8});
    end
    bus.state = 2'd3;
    repeat (10) step("illegal");
    check("illegal.hold", bus.digits, 32'h2187_6543);

    // asynchronous reset mid-ROTATE
    bus.state = 2'd2;
    repeat (2) step("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check("areset.digits", bus.digits, 32'h0);
    check("areset.an", {24'd0, bus.an}, 32'hFE);
    check("areset.tick", {31'd0, bus.rot_tick}, 32'd0);
    model_reset();
    bus.state = 2'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) step("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
